// File: rtl/fetch_control.sv
// Fetch/issue controller: assembles one- and two-word AVR instructions from a
// registered program ROM, issues them to execute over valid/ready, and steers
// the program counter for relative, absolute and conditional control flow.
module fetch_control #(
    parameter int unsigned PC_W = 14
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [15:0]     instruction,
    input  logic [PC_W-1:0] program_counter,
    output logic            PC_inc,
    output logic            PC_overwrite,
    output logic [PC_W-1:0] PC_new,
    input  logic [7:0]      sreg,
    input  logic            ex_ready,
    input  logic            ex_redirect,
    input  logic [PC_W-1:0] ex_target,
    input  logic            ex_skip,
    output logic            ir_valid,
    output logic [15:0]     ir_word,
    output logic [15:0]     ir_ext,
    output logic [PC_W-1:0] ir_pc,
    output logic            ir_two
);

    localparam int unsigned IW = 16;

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_WAIT2  = 3'd2,
        S_EXT    = 3'd3,
        S_ISSUE  = 3'd4
    } state_e;

    state_e          state_q;
    logic            skip_pending_q;
    logic            ir_valid_q;
    logic            ir_two_q;
    logic [IW-1:0]   ir_word_q;
    logic [IW-1:0]   ir_ext_q;
    logic [PC_W-1:0] ir_pc_q;

    logic            in_jmp_call_c;
    logic            in_lds_sts_c;
    logic            in_two_word_c;

    logic            is_rjmp_c;
    logic            is_branch_c;
    logic            is_jmp_call_c;
    logic            br_taken_c;
    logic            handshake_c;
    logic [PC_W-1:0] pc_plus1_c;
    logic [PC_W-1:0] rel12_tgt_c;
    logic [PC_W-1:0] rel7_tgt_c;
    logic [PC_W-1:0] abs_tgt_c;

    logic            pc_inc_c;
    logic            pc_overwrite_c;
    logic [PC_W-1:0] pc_new_c;

    // Classify the word arriving from program memory as one- or two-word
    always_comb begin
        in_jmp_call_c = (instruction[15:9] == 7'b1001010) && (instruction[3:2] == 2'b11);
        in_lds_sts_c  = ((instruction[15:9] == 7'b1001000) || (instruction[15:9] == 7'b1001001))
                        && (instruction[3:0] == 4'b0000);
        in_two_word_c = in_jmp_call_c || in_lds_sts_c;
    end

    // Control-flow decode and target arithmetic for the instruction being issued
    always_comb begin
        is_rjmp_c     = (ir_word_q[15:13] == 3'b110);
        is_branch_c   = (ir_word_q[15:11] == 5'b11110);
        is_jmp_call_c = (ir_word_q[15:9] == 7'b1001010) && (ir_word_q[3:2] == 2'b11);
        // BRBS (b=0) is taken on a set flag, BRBC (b=1) on a clear flag
        br_taken_c    = (sreg[ir_word_q[2:0]] != ir_word_q[10]);
        pc_plus1_c    = ir_pc_q + PC_W'(1);
        rel12_tgt_c   = pc_plus1_c + PC_W'($signed(ir_word_q[11:0]));
        rel7_tgt_c    = pc_plus1_c + PC_W'($signed(ir_word_q[9:3]));
        abs_tgt_c     = PC_W'(ir_ext_q);
        // A redirect in the same cycle cancels the handshake
        handshake_c   = ir_valid_q && ex_ready && !ex_redirect;
    end

    // Program-counter requests towards program memory
    always_comb begin
        pc_inc_c       = 1'b0;
        pc_overwrite_c = 1'b0;
        pc_new_c       = '0;
        unique case (state_q)
            S_DECODE: begin
                if (in_two_word_c || skip_pending_q) begin
                    pc_inc_c = 1'b1;
                end
            end
            S_EXT: begin
                if (skip_pending_q) begin
                    pc_inc_c = 1'b1;
                end
            end
            S_ISSUE: begin
                if (handshake_c) begin
                    if (is_rjmp_c) begin
                        pc_overwrite_c = 1'b1;
                        pc_new_c       = rel12_tgt_c;
                    end else if (is_branch_c && br_taken_c) begin
                        pc_overwrite_c = 1'b1;
                        pc_new_c       = rel7_tgt_c;
                    end else if (is_jmp_call_c) begin
                        pc_overwrite_c = 1'b1;
                        pc_new_c       = abs_tgt_c;
                    end else begin
                        // LDS/STS land here too: the PC already sits on their second word
                        pc_inc_c = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
        if (ex_redirect) begin
            pc_inc_c       = 1'b0;
            pc_overwrite_c = 1'b1;
            pc_new_c       = ex_target;
        end
        // Requests vanish the moment reset asserts, even between clock edges
        if (!reset_n) begin
            pc_inc_c       = 1'b0;
            pc_overwrite_c = 1'b0;
            pc_new_c       = '0;
        end
    end

    // Fetch FSM with the registered instruction hand-off to execute
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_WAIT;
            skip_pending_q <= 1'b0;
            ir_valid_q     <= 1'b0;
            ir_two_q       <= 1'b0;
            ir_word_q      <= '0;
            ir_ext_q       <= '0;
            ir_pc_q        <= '0;
        end else begin
            unique case (state_q)
                S_WAIT: begin
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    ir_word_q <= instruction;
                    ir_pc_q   <= program_counter;
                    ir_ext_q  <= '0;
                    if (in_two_word_c) begin
                        ir_two_q <= 1'b1;
                        state_q  <= S_WAIT2;
                    end else begin
                        ir_two_q <= 1'b0;
                        if (skip_pending_q) begin
                            skip_pending_q <= 1'b0;
                            state_q        <= S_WAIT;
                        end else begin
                            ir_valid_q <= 1'b1;
                            state_q    <= S_ISSUE;
                        end
                    end
                end
                S_WAIT2: begin
                    state_q <= S_EXT;
                end
                S_EXT: begin
                    ir_ext_q <= instruction;
                    if (skip_pending_q) begin
                        skip_pending_q <= 1'b0;
                        state_q        <= S_WAIT;
                    end else begin
                        ir_valid_q <= 1'b1;
                        state_q    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (ex_ready) begin
                        ir_valid_q <= 1'b0;
                        state_q    <= S_WAIT;
                    end
                end
                default: begin
                    ir_valid_q <= 1'b0;
                    state_q    <= S_WAIT;
                end
            endcase
            // A new skip request outranks the consumption of an older one
            if (ex_skip) begin
                skip_pending_q <= 1'b1;
            end
            // Redirect outranks everything, including a coincident skip
            if (ex_redirect) begin
                skip_pending_q <= 1'b0;
                ir_valid_q     <= 1'b0;
                state_q        <= S_WAIT;
            end
        end
    end

    assign PC_inc       = pc_inc_c;
    assign PC_overwrite = pc_overwrite_c;
    assign PC_new       = pc_new_c;
    assign ir_valid     = ir_valid_q;
    assign ir_word      = ir_word_q;
    assign ir_ext       = ir_ext_q;
    assign ir_pc        = ir_pc_q;
    assign ir_two       = ir_two_q;

endmodule

// File: tb/tb_fetch_control.sv
// Bench for fetch_control: a registered program ROM plus an instruction-level
// model of the AVR control-flow rules that predicts every issued instruction.
module tb_fetch_control;

    localparam int unsigned PC_W = 14;
    localparam int          MASK = (1 << PC_W) - 1;

    logic            clk;
    logic            reset_n;
    logic [15:0]     instruction;
    logic [PC_W-1:0] program_counter;
    logic            PC_inc;
    logic            PC_overwrite;
    logic [PC_W-1:0] PC_new;
    logic [7:0]      sreg;
    logic            ex_ready;
    logic            ex_redirect;
    logic [PC_W-1:0] ex_target;
    logic            ex_skip;
    logic            ir_valid;
    logic [15:0]     ir_word;
    logic [15:0]     ir_ext;
    logic [PC_W-1:0] ir_pc;
    logic            ir_two;

    logic [15:0]     mem [0:MASK];
    int              checks;
    int              errors;

    fetch_control #(.PC_W(PC_W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .instruction    (instruction),
        .program_counter(program_counter),
        .PC_inc         (PC_inc),
        .PC_overwrite   (PC_overwrite),
        .PC_new         (PC_new),
        .sreg           (sreg),
        .ex_ready       (ex_ready),
        .ex_redirect    (ex_redirect),
        .ex_target      (ex_target),
        .ex_skip        (ex_skip),
        .ir_valid       (ir_valid),
        .ir_word        (ir_word),
        .ir_ext         (ir_ext),
        .ir_pc          (ir_pc),
        .ir_two         (ir_two)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program memory: PC register plus a registered read of the word at the PC
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            program_counter <= '0;
            instruction     <= '0;
        end else begin
            instruction <= mem[program_counter];
            if (PC_overwrite)  program_counter <= PC_new;
            else if (PC_inc)   program_counter <= program_counter + PC_W'(1);
        end
    end

    function automatic bit is_two(input logic [15:0] w);
        return (w ==? 16'b1001_010?_????_110?) || (w ==? 16'b1001_010?_????_111?) ||
               (w ==? 16'b1001_000?_????_0000) || (w ==? 16'b1001_001?_????_0000);
    endfunction

    // Architectural next PC of the instruction at pc, and whether it is a jump
    function automatic void model_step(input int pc, input logic [7:0] sr, output int nxt, output bit ow);
        logic [15:0] w;
        int k;
        w  = mem[pc];
        ow = 1'b1;
        if (w ==? 16'b110?_????_????_????) begin
            k = int'(w[11:0]);
            if (k >= 2048) k -= 4096;
            nxt = (pc + 1 + k) & MASK;
        end else if (w ==? 16'b1111_0???_????_????) begin
            k = int'(w[9:3]);
            if (k >= 64) k -= 128;
            if (sr[w[2:0]] != w[10]) nxt = (pc + 1 + k) & MASK;
            else begin nxt = (pc + 1) & MASK; ow = 1'b0; end
        end else if ((w ==? 16'b1001_010?_????_110?) || (w ==? 16'b1001_010?_????_111?)) begin
            nxt = int'(mem[(pc + 1) & MASK]) & MASK;
        end else begin
            ow  = 1'b0;
            nxt = (pc + (is_two(w) ? 2 : 1)) & MASK;
        end
    endfunction

    task automatic clear_mem();
        for (int a = 0; a <= MASK; a++) mem[a] = 16'h0000;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0; ex_redirect = 1'b0; ex_skip = 1'b0; ex_target = '0; sreg = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_valid(input int budget, output bit ok, output int cycles);
        ok = 1'b0; cycles = 0;
        while (!ok && cycles < budget) begin
            @(negedge clk); #1;
            cycles++;
            if (ir_valid) ok = 1'b1;
        end
    endtask

    task automatic redirect_on(input logic [PC_W-1:0] t);
        @(negedge clk);
        ex_redirect = 1'b1; ex_target = t;
        #1;
    endtask

    task automatic redirect_off();
        @(negedge clk);
        ex_redirect = 1'b0;
    endtask

    task automatic test_reset();
        clear_mem();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({PC_inc, PC_overwrite, PC_new, ir_valid, ir_word, ir_ext, ir_pc, ir_two} !== '0) begin
            errors++; $display("FAIL reset_outputs got inc=%b ow=%b new=%h v=%b w=%h e=%h pc=%h two=%b required all 0",
                               PC_inc, PC_overwrite, PC_new, ir_valid, ir_word, ir_ext, ir_pc, ir_two);
        end
    endtask

    task automatic test_nop_stream();
        clear_mem(); ex_ready = 1'b1;
        apply_reset(); #1;
        for (int c = 0; c < 9; c++) begin
            if (c > 0) begin @(negedge clk); #1; end
            checks++;
            if (ir_valid !== 1'(c % 3 == 2)) begin
                errors++; $display("FAIL nop_valid cyc %0d got %b required %b", c, ir_valid, (c % 3 == 2));
            end
            checks++;
            if (PC_inc !== 1'(c % 3 == 2) || PC_overwrite !== 1'b0) begin
                errors++; $display("FAIL nop_pcreq cyc %0d got inc=%b ow=%b required inc=%b ow=0", c, PC_inc, PC_overwrite, (c % 3 == 2));
            end
            if (c % 3 == 2) begin
                checks++;
                if (ir_pc !== PC_W'(c / 3)) begin
                    errors++; $display("FAIL nop_pc cyc %0d got %h required %h", c, ir_pc, c / 3);
                end
            end
        end
    endtask

    task automatic test_jmp();
        bit ok; int cyc;
        clear_mem(); mem[5] = 16'h940C; mem[6] = 16'h0123; ex_ready = 1'b1;
        apply_reset();
        for (int i = 0; i < 5; i++) wait_valid(10, ok, cyc);
        wait_valid(10, ok, cyc);
        checks++;
        if (!ok || cyc != 5) begin
            errors++; $display("FAIL jmp_latency got ok=%b cycles=%0d required 5", ok, cyc);
        end
        checks++;
        if (ir_pc !== 14'h0005 || ir_word !== 16'h940C || ir_two !== 1'b1 || ir_ext !== 16'h0123) begin
            errors++; $display("FAIL jmp_ir got pc=%h w=%h two=%b ext=%h required 0005 940c 1 0123", ir_pc, ir_word, ir_two, ir_ext);
        end
        checks++;
        if (PC_overwrite !== 1'b1 || PC_inc !== 1'b0 || PC_new !== 14'h0123) begin
            errors++; $display("FAIL jmp_pcreq got ow=%b inc=%b new=%h required 1 0 0123", PC_overwrite, PC_inc, PC_new);
        end
        wait_valid(10, ok, cyc);
        checks++;
        if (!ok || ir_pc !== 14'h0123 || ir_two !== 1'b0 || ir_ext !== 16'h0000 || cyc != 3) begin
            errors++; $display("FAIL jmp_target got ok=%b pc=%h two=%b ext=%h cycles=%0d required 0123 0 0000 3", ok, ir_pc, ir_two, ir_ext, cyc);
        end
    endtask

    task automatic test_rjmp_wrap();
        bit ok; int cyc;
        clear_mem(); mem[16'h0010] = 16'hCFFF; mem[16'h3FFF] = 16'hC7FF; ex_ready = 1'b1;
        apply_reset();
        redirect_on(14'h0010);
        checks++;
        if (PC_overwrite !== 1'b1 || PC_inc !== 1'b0 || PC_new !== 14'h0010) begin
            errors++; $display("FAIL redirect_req got ow=%b inc=%b new=%h required 1 0 0010", PC_overwrite, PC_inc, PC_new);
        end
        redirect_off();
        wait_valid(10, ok, cyc);
        checks++;
        if (!ok || ir_pc !== 14'h0010 || PC_overwrite !== 1'b1 || PC_new !== 14'h0010) begin
            errors++; $display("FAIL rjmp_self got ok=%b pc=%h ow=%b new=%h required 0010 1 0010", ok, ir_pc, PC_overwrite, PC_new);
        end
        redirect_on(14'h3FFF);
        redirect_off();
        wait_valid(10, ok, cyc);
        checks++;
        if (!ok || ir_pc !== 14'h3FFF || PC_overwrite !== 1'b1 || PC_new !== 14'h07FF) begin
            errors++; $display("FAIL rjmp_wrap got ok=%b pc=%h ow=%b new=%h required 3fff 1 07ff", ok, ir_pc, PC_overwrite, PC_new);
        end
    endtask

    task automatic test_branch();
        bit ok; int cyc;
        clear_mem(); mem[16'h0020] = 16'hF3F1; ex_ready = 1'b1;
        apply_reset();
        sreg = 8'h02;
        redirect_on(14'h0020);
        redirect_off();
        wait_valid(10, ok, cyc);
        checks++;
        if (!ok || ir_pc !== 14'h0020 || PC_overwrite !== 1'b1 || PC_inc !== 1'b0 || PC_new !== 14'h001F) begin
            errors++; $display("FAIL brbs_taken got ok=%b pc=%h ow=%b inc=%b new=%h required 0020 1 0 001f", ok, ir_pc, PC_overwrite, PC_inc, PC_new);
        end
        wait_valid(10, ok, cyc);
        checks++;
        if (!ok || ir_pc !== 14'h001F) begin
            errors++; $display("FAIL brbs_dest got ok=%b pc=%h required 001f", ok, ir_pc);
        end
        sreg = 8'hFD;
        wait_valid(10, ok, cyc);
        checks++;
        if (!ok || ir_pc !== 14'h0020 || PC_overwrite !== 1'b0 || PC_inc !== 1'b1) begin
            errors++; $display("FAIL brbs_not_taken got ok=%b pc=%h ow=%b inc=%b required 0020 0 1", ok, ir_pc, PC_overwrite, PC_inc);
        end
        wait_valid(10, ok, cyc);
        checks++;
        if (!ok || ir_pc !== 14'h0021) begin
            errors++; $display("FAIL brbs_fallthrough got ok=%b pc=%h required 0021", ok, ir_pc);
        end
        sreg = 8'h00;
    endtask

    task automatic test_skip();
        bit ok; int cyc;
        clear_mem(); mem[16'h0041] = 16'h9100; mem[16'h0042] = 16'hABCD; ex_ready = 1'b1;
        apply_reset();
        redirect_on(14'h0040);
        redirect_off();
        wait_valid(10, ok, cyc);
        checks++;
        if (!ok || ir_pc !== 14'h0040) begin
            errors++; $display("FAIL skip_setup got ok=%b pc=%h required 0040", ok, ir_pc);
        end
        ex_skip = 1'b1;
        @(negedge clk);
        ex_skip = 1'b0;
        wait_valid(20, ok, cyc);
        checks++;
        if (!ok || ir_pc !== 14'h0043 || ir_two !== 1'b0 || cyc + 1 != 7) begin
            errors++; $display("FAIL skip_lds got ok=%b pc=%h two=%b cycles=%0d required 0043 0 7", ok, ir_pc, ir_two, cyc + 1);
        end
    endtask

    task automatic test_stall_redirect_reset();
        bit ok; int cyc;
        clear_mem(); mem[16'h0200] = 16'h940C; mem[16'h0201] = 16'h0300; ex_ready = 1'b0;
        apply_reset();
        wait_valid(10, ok, cyc);
        checks++;
        if (!ok || ir_pc !== 14'h0000) begin
            errors++; $display("FAIL stall_setup got ok=%b pc=%h required 0000", ok, ir_pc);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            checks++;
            if (ir_valid !== 1'b1 || ir_pc !== 14'h0000 || PC_inc !== 1'b0 || PC_overwrite !== 1'b0) begin
                errors++; $display("FAIL stall_hold %0d got v=%b pc=%h inc=%b ow=%b required 1 0000 0 0", i, ir_valid, ir_pc, PC_inc, PC_overwrite);
            end
        end
        ex_ready = 1'b1;
        redirect_on(14'h0200);
        checks++;
        if (PC_overwrite !== 1'b1 || PC_inc !== 1'b0 || PC_new !== 14'h0200) begin
            errors++; $display("FAIL stall_redirect got ow=%b inc=%b new=%h required 1 0 0200", PC_overwrite, PC_inc, PC_new);
        end
        redirect_off(); #1;
        checks++;
        if (ir_valid !== 1'b0) begin
            errors++; $display("FAIL redirect_drop got v=%b required 0", ir_valid);
        end
        @(negedge clk); #1;
        checks++;
        if (PC_inc !== 1'b1 || PC_overwrite !== 1'b0) begin
            errors++; $display("FAIL decode_two got inc=%b ow=%b required 1 0", PC_inc, PC_overwrite);
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({PC_inc, PC_overwrite, PC_new, ir_valid, ir_word, ir_ext, ir_pc, ir_two} !== '0) begin
            errors++; $display("FAIL reset_mid_fetch got inc=%b ow=%b new=%h v=%b w=%h e=%h pc=%h two=%b required all 0",
                               PC_inc, PC_overwrite, PC_new, ir_valid, ir_word, ir_ext, ir_pc, ir_two);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_random();
        int model_pc, nxt, hs, r;
        bit model_skip, ow;
        logic [15:0] exp_w, exp_e;
        for (int a = 0; a <= MASK; a++) begin
            r = $urandom_range(0, 9);
            case (r)
                4:       mem[a] = 16'hC000 | 16'($urandom & 32'h1FFF);
                5, 6:    mem[a] = 16'hF000 | 16'($urandom & 32'h07FF);
                7:       mem[a] = 16'h940C | 16'($urandom & 32'h01F3);
                8:       mem[a] = 16'h9000 | 16'($urandom & 32'h01F0) | (($urandom & 1) != 0 ? 16'h0200 : 16'h0000);
                9:       mem[a] = 16'h0000;
                default: mem[a] = 16'($urandom);
            endcase
        end
        ex_ready = 1'b0;
        apply_reset();
        model_pc = 0; model_skip = 1'b0; hs = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            ex_ready    = ($urandom_range(0, 3) != 0);
            sreg        = 8'($urandom);
            ex_redirect = ($urandom_range(0, 39) == 0);
            ex_target   = PC_W'($urandom_range(0, MASK));
            ex_skip     = (!ex_redirect && ir_valid && ex_ready && $urandom_range(0, 5) == 0);
            #1;
            checks++;
            if (PC_inc && PC_overwrite) begin
                errors++; $display("FAIL rnd_both_req cyc %0d got inc=1 ow=1 required not both", cyc);
            end
            if (ex_redirect) begin
                checks++;
                if (PC_overwrite !== 1'b1 || PC_inc !== 1'b0 || PC_new !== ex_target) begin
                    errors++; $display("FAIL rnd_redirect cyc %0d got ow=%b inc=%b new=%h required 1 0 %h", cyc, PC_overwrite, PC_inc, PC_new, ex_target);
                end
                model_pc = int'(ex_target); model_skip = 1'b0;
            end else if (ir_valid && ex_ready) begin
                if (model_skip) begin
                    model_pc = (model_pc + (is_two(mem[model_pc]) ? 2 : 1)) & MASK;
                    model_skip = 1'b0;
                end
                exp_w = mem[model_pc];
                exp_e = is_two(exp_w) ? mem[(model_pc + 1) & MASK] : 16'h0000;
                checks++;
                if (ir_pc !== PC_W'(model_pc) || ir_word !== exp_w || ir_two !== is_two(exp_w) || ir_ext !== exp_e) begin
                    errors++; $display("FAIL rnd_issue cyc %0d got pc=%h w=%h two=%b e=%h required %h %h %b %h",
                                       cyc, ir_pc, ir_word, ir_two, ir_ext, PC_W'(model_pc), exp_w, is_two(exp_w), exp_e);
                end
                model_step(model_pc, sreg, nxt, ow);
                checks++;
                if (ow ? (PC_overwrite !== 1'b1 || PC_inc !== 1'b0 || PC_new !== PC_W'(nxt))
                       : (PC_overwrite !== 1'b0 || PC_inc !== 1'b1)) begin
                    errors++; $display("FAIL rnd_pcreq cyc %0d got ow=%b inc=%b new=%h required ow=%b next=%h",
                                       cyc, PC_overwrite, PC_inc, PC_new, ow, PC_W'(nxt));
                end
                model_pc = nxt; hs++;
                if (ex_skip) model_skip = 1'b1;
            end else if (ir_valid) begin
                checks++;
                if (PC_inc !== 1'b0 || PC_overwrite !== 1'b0) begin
                    errors++; $display("FAIL rnd_stall cyc %0d got inc=%b ow=%b required 0 0", cyc, PC_inc, PC_overwrite);
                end
            end
        end
        @(negedge clk);
        ex_redirect = 1'b0; ex_skip = 1'b0; ex_ready = 1'b0;
        checks++;
        if (hs < 100) begin
            errors++; $display("FAIL rnd_progress got %0d handshakes required at least 100", hs);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset_n = 1'b1; ex_ready = 1'b0; ex_redirect = 1'b0; ex_skip = 1'b0;
        ex_target = '0; sreg = '0;
        #2;
        test_reset();
        test_nop_stream();
        test_jmp();
        test_rjmp_wrap();
        test_branch();
        test_skip();
        test_stall_redirect_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_control.md
Name: fetch_control

Overview:
- Instruction fetch/issue controller sitting directly downstream of the program-memory stage.
- Consumes `instruction` and `program_counter`, and drives that stage's `PC_inc`, `PC_overwrite` and `PC_new`.
- Assembles one- and two-word AVR instructions, resolves relative, absolute and conditional control flow, and hands instructions to the execute stage over a valid/ready handshake.
- Handles execute-stage redirects (RET/RETI/IJMP/ICALL) and skip requests (CPSE/SBRC/SBRS/SBIC/SBIS).

Parameters:
- PC_W, 14, program-counter width in words; all PC arithmetic is modulo 2^PC_W.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- instruction  in  16  program word at program_counter; valid one cycle after the PC changes (registered ROM)
- program_counter  in  PC_W  current PC from program memory
- PC_inc  out  1  request PC+1 at next clk edge
- PC_overwrite  out  1  request PC=PC_new at next clk edge; program memory gives it priority over PC_inc
- PC_new  out  PC_W  target PC
- sreg  in  8  status register from execute; settled whenever ex_ready=1
- ex_ready  in  1  execute can accept an instruction; all prior instructions are complete
- ex_redirect  in  1  single-cycle pulse, load ex_target
- ex_target  in  PC_W  redirect target
- ex_skip  in  1  single-cycle pulse, discard next instruction
- ir_valid  out  1  ir_word/ir_ext/ir_pc/ir_two hold an instruction for execute
- ir_word  out  16  first instruction word
- ir_ext  out  16  second word for two-word instructions, else 0
- ir_pc  out  PC_W  address of the first word
- ir_two  out  1  instruction is two words; return address = ir_pc+1+ir_two

Behaviour:
- Reset state: state=WAIT, skip_pending=0, ir_valid=0, ir_word=0, ir_ext=0, ir_pc=0, ir_two=0, PC_inc=0, PC_overwrite=0, PC_new=0.
- Reset is effective immediately whenever it asserts, including mid-fetch.
- PC_inc, PC_overwrite and PC_new are combinational from state and inputs. They are never both 1 in one cycle.
- Two-word classes:
  - JMP: 1001010x_xxxx110x
  - CALL: 1001010x_xxxx111x
  - LDS: 1001000x_xxxx0000
  - STS: 1001001x_xxxx0000
- States:
  - WAIT: no PC request; go to DECODE (covers the ROM latency).
  - DECODE: latch ir_word=instruction, ir_pc=program_counter, ir_ext=0.
    - Two-word: set ir_two=1, assert PC_inc, go to WAIT2.
    - Otherwise: set ir_two=0. If skip_pending, clear it, assert PC_inc, go to WAIT (instruction discarded). Else go to ISSUE.
  - WAIT2: no request; go to EXT.
  - EXT: latch ir_ext=instruction.
    - If skip_pending: clear it, assert PC_inc, go to WAIT (both words discarded).
    - Else go to ISSUE.
  - ISSUE: ir_valid=1. Hold until ir_valid&ex_ready, then in that cycle drive the PC update for ir_word and go to WAIT with ir_valid=0 next cycle. PC update per instruction:
    - RJMP/RCALL (110x kkkk_kkkk_kkkk): PC_overwrite, PC_new=ir_pc+1+sext(k12).
    - BRBS/BRBC (11110b kkkkkkk sss): taken if sreg[s]==~b, giving PC_overwrite, PC_new=ir_pc+1+sext(k7). Not taken gives PC_inc.
    - JMP/CALL: PC_overwrite, PC_new=ir_ext[PC_W-1:0]; the high address bits in ir_word are ignored.
    - All others, including LDS/STS: PC_inc. For LDS/STS the PC already points at the second word.
- ex_redirect:
  - Highest priority, honoured in any state.
  - Drives PC_overwrite with PC_new=ex_target in the same cycle, goes to WAIT, ir_valid=0 next cycle, skip_pending=0.
  - A handshake coinciding with a redirect is cancelled: execute must ignore it.
- ex_skip: sets skip_pending. A coincident ex_redirect wins and clears it.
- Wrap-around: ir_pc=0x3FFF with RJMP k=0 gives PC_new=0x0000. Negative offsets wrap modulo 2^14.
- Throughput: 3 cycles per one-word instruction and 5 per two-word instruction with ex_ready held high.

Test Plan:
- Reset, ROM 0x0000=NOP(0x0000), ex_ready=1 -> ir_valid first at cycle 3 with ir_pc=0; PC_inc pulses once per 3 cycles; ir_pc sequence 0,1,2.
- 0x0005=0x940C, 0x0006=0x0123 (JMP 0x123) -> ir_two=1, ir_ext=0x0123; at handshake PC_overwrite=1, PC_new=0x0123.
- RJMP 0xCFFF at 0x0010 -> PC_new=0x0010; RJMP 0xC7FF at 0x3FFF -> PC_new=0x07FF (wrap).
- BRBS Z (0xF3F1, k=-2) at 0x20: with sreg[1]=1 -> PC_new=0x1F; with sreg[1]=0 -> PC_inc only.
- ex_skip pulse, next word LDS (0x9100, 0xABCD) -> both words discarded, no ir_valid, PC advances by 2, then the following instruction issues.
- ir_valid held with ex_ready=0 for 4 cycles -> outputs stable, no PC request; ex_redirect to 0x0200 asserted then -> PC_overwrite same cycle, ir_valid=0 next cycle; reset_n low mid-WAIT2 -> all outputs 0 immediately.
